rf_scoreboard: RTL and testbench

//  Parametrised register file for the pipelined datapath. Two async read ports,
//  two sync write ports, optional hardwired-zero register, optional write-to-read

---
 rtl/rf_scoreboard_if.sv | 33 +++
 rtl/rf_scoreboard.sv | 83 ++++++++
 tb/tb_rf_scoreboard.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: two read ports with busy
// flags, two write ports and the destination-register issue strobe.
interface rf_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    modport master (
        output rs_addr, rt_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, issue_en, issue_addr,
        input  rs_data, rt_data, rs_busy, rt_busy
    );

    modport slave (
        input  rs_addr, rt_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, issue_en, issue_addr,
        output rs_data, rt_data, rs_busy, rt_busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, two clocked write ports,
// optional hardwired zero register, optional write bypass and a RAW busy scoreboard.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_scoreboard_if.slave bus
);
    localparam bit ZERO = (ZERO_REG != 0);
    localparam bit BYP  = (BYPASS != 0);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    // Anything aimed at the hardwired zero register is dropped up front, so the
    // per-register logic below never has to special-case address 0.
    logic wa_eff, wb_eff, iss_eff;
    assign wa_eff  = bus.wa_en    && !(ZERO && (bus.wa_addr    == '0));
    assign wb_eff  = bus.wb_en    && !(ZERO && (bus.wb_addr    == '0));
    assign iss_eff = bus.issue_en && !(ZERO && (bus.issue_addr == '0));

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        logic wr_a, wr_b, iss;
        assign wr_a = wa_eff  && (bus.wa_addr    == ADDR_W'(r));
        assign wr_b = wb_eff  && (bus.wb_addr    == ADDR_W'(r));
        assign iss  = iss_eff && (bus.issue_addr == ADDR_W'(r));

        always_comb begin
            regs_d[r] = regs_q[r];
            if (wr_b)      regs_d[r] = bus.wb_data;
            else if (wr_a) regs_d[r] = bus.wa_data;
        end

        // A new producer issued in the same cycle as a writeback keeps the register busy.
        always_comb begin
            busy_d[r] = busy_q[r];
            if (iss)              busy_d[r] = 1'b1;
            else if (wr_a || wr_b) busy_d[r] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             rd_busy;
    assign rd_addr = {bus.rt_addr, bus.rs_addr};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic hit_a, hit_b, is_zero;
        assign hit_a   = BYP && wa_eff && (bus.wa_addr == rd_addr[p]);
        assign hit_b   = BYP && wb_eff && (bus.wb_addr == rd_addr[p]);
        assign is_zero = ZERO && (rd_addr[p] == '0);

        // Port B is the later writer, so it also wins the forward path.
        always_comb begin
            rd_data[p] = regs_q[rd_addr[p]];
            if (is_zero)    rd_data[p] = '0;
            else if (hit_b) rd_data[p] = bus.wb_data;
            else if (hit_a) rd_data[p] = bus.wa_data;
        end

        assign rd_busy[p] = busy_q[rd_addr[p]] && !is_zero && !(hit_a || hit_b);
    end

    assign bus.rs_data = rd_data[0];
    assign bus.rt_data = rd_data[1];
    assign bus.rs_busy = rd_busy[0];
    assign bus.rt_busy = rd_busy[1];
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench: a vector table against the bypassing instance, plus hand-written
// sequences for the non-bypassing instance and asynchronous reset.
module tb_rf_scoreboard;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rf_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    rf_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

    rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bus(bus_nb)
    );

    assign bus_nb.rs_addr    = bus.rs_addr;
    assign bus_nb.rt_addr    = bus.rt_addr;
    assign bus_nb.wa_en      = bus.wa_en;
    assign bus_nb.wa_addr    = bus.wa_addr;
    assign bus_nb.wa_data    = bus.wa_data;
    assign bus_nb.wb_en      = bus.wb_en;
    assign bus_nb.wb_addr    = bus.wb_addr;
    assign bus_nb.wb_data    = bus.wb_data;
    assign bus_nb.issue_en   = bus.issue_en;
    assign bus_nb.issue_addr = bus.issue_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] ers;
        logic [31:0] ert;
        logic        erb;
        logic        etb;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                                input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] ers, input logic [31:0] ert,
                                input logic erb, input logic etb);
        vec_t v;
        v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
        v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
        v.iss_en = ie; v.iss_addr = ia;
        v.rs = rs; v.rt = rt; v.ers = ers; v.ert = ert; v.erb = erb; v.etb = etb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wa_en = v.wa_en; bus.wa_addr = v.wa_addr; bus.wa_data = v.wa_data;
        bus.wb_en = v.wb_en; bus.wb_addr = v.wb_addr; bus.wb_data = v.wb_data;
        bus.issue_en = v.iss_en; bus.issue_addr = v.iss_addr;
        bus.rs_addr = v.rs; bus.rt_addr = v.rt;
    endtask

    vec_t idle;

    initial begin
        total = 0;
        bad   = 0;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //          wa_en/addr/data          wb_en/addr/data           iss     rs  rt  exp_rs        exp_rt        rsb rtb
        tbl[0]  = mk(0, 0, 0,                0, 0, 0,                  0, 0,   0,  5,  32'h0,        32'h0,        0, 0);
        tbl[1]  = mk(1, 3, 32'h1234,         0, 0, 0,                  0, 0,   3,  4,  32'h1234,     32'h0,        0, 0);
        tbl[2]  = mk(0, 0, 0,                0, 0, 0,                  0, 0,   3,  3,  32'h1234,     32'h1234,     0, 0);
        tbl[3]  = mk(1, 3, 32'h1111,         1, 3, 32'h5678,           0, 0,   3,  1,  32'h5678,     32'h0,        0, 0);
        tbl[4]  = mk(0, 0, 0,                0, 0, 0,                  0, 0,   3,  3,  32'h5678,     32'h5678,     0, 0);
        tbl[5]  = mk(1, 7, 32'hCAFE,         0, 0, 0,                  0, 0,   7,  7,  32'hCAFE,     32'hCAFE,     0, 0);
        tbl[6]  = mk(1, 0, 32'hFFFF_FFFF,    0, 0, 0,                  1, 0,   0,  0,  32'h0,        32'h0,        0, 0);
        tbl[7]  = mk(0, 0, 0,                1, 0, 32'hFFFF_FFFF,      0, 0,   0,  0,  32'h0,        32'h0,        0, 0);
        tbl[8]  = mk(0, 0, 0,                0, 0, 0,                  1, 9,   9,  7,  32'h0,        32'hCAFE,     0, 0);
        tbl[9]  = mk(0, 0, 0,                0, 0, 0,                  0, 0,   9,  9,  32'h0,        32'h0,        1, 1);
        tbl[10] = mk(0, 0, 0,                1, 9, 32'hBEEF,           0, 0,   9,  2,  32'hBEEF,     32'h0,        0, 0);
        tbl[11] = mk(0, 0, 0,                0, 0, 0,                  0, 0,   9,  9,  32'hBEEF,     32'hBEEF,     0, 0);
        tbl[12] = mk(1, 9, 32'h9999,         0, 0, 0,                  1, 9,   9,  3,  32'h9999,     32'h5678,     0, 0);
        tbl[13] = mk(0, 0, 0,                0, 0, 0,                  0, 0,   9,  0,  32'h9999,     32'h0,        1, 0);
        tbl[14] = mk(0, 0, 0,                0, 0, 0,                  1, 4,   4,  9,  32'h0,        32'h9999,     0, 1);
        tbl[15] = mk(0, 0, 0,                0, 0, 0,                  0, 0,   4,  0,  32'h0,        32'h0,        1, 0);

        rst_n = 1'b0;
        drive(idle);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d rs_data", i), bus.rs_data, tbl[i].ers);
            chk($sformatf("v%0d rt_data", i), bus.rt_data, tbl[i].ert);
            chk($sformatf("v%0d rs_busy", i), 32'(bus.rs_busy), 32'(tbl[i].erb));
            chk($sformatf("v%0d rt_busy", i), 32'(bus.rt_busy), 32'(tbl[i].etb));
        end

        // Write R5 while busy[4] is still set, then pull reset between edges.
        @(negedge clk);
        drive(mk(1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 5, 4, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 4, 0, 0, 0, 0));
        #1;
        chk("pre-rst R5", bus.rs_data, 32'hDEAD);
        chk("pre-rst busy4", 32'(bus.rt_busy), 32'd1);
        chk("pre-rst nb busy4", 32'(bus_nb.rt_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst R5", bus.rs_data, 32'h0);
        chk("async rst busy4", 32'(bus.rt_busy), 32'd0);
        chk("async rst nb R5", bus_nb.rs_data, 32'h0);
        chk("async rst nb busy4", 32'(bus_nb.rt_busy), 32'd0);

        // Writes and issues while reset is held leave no trace.
        drive(mk(1, 6, 32'h6666, 0, 0, 0, 1, 6, 6, 6, 0, 0, 0, 0));
        @(negedge clk);
        drive(idle);
        bus.rs_addr = 6;
        #1;
        chk("held rst R6", bus.rs_data, 32'h0);
        chk("held rst busy6", 32'(bus.rs_busy), 32'd0);
        rst_n = 1'b1;

        // No-bypass instance: old value and unmasked busy until the edge.
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 7, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 7, 32'hCAFE, 1, 9, 32'h0BAD, 0, 0, 9, 7, 0, 0, 0, 0));
        #1;
        chk("nb rt old", bus_nb.rt_data, 32'h0);
        chk("nb rs old", bus_nb.rs_data, 32'h0);
        chk("nb rs busy unmasked", 32'(bus_nb.rs_busy), 32'd1);
        chk("byp rt fwd", bus.rt_data, 32'hCAFE);
        chk("byp rs busy masked", 32'(bus.rs_busy), 32'd0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 0, 0, 0, 0));
        #1;
        chk("nb rt after edge", bus_nb.rt_data, 32'hCAFE);
        chk("nb rs after edge", bus_nb.rs_data, 32'h0BAD);
        chk("nb rs busy cleared", 32'(bus_nb.rs_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
